mac_seq_tg: RTL



---
 rtl/mac_seq_pkg.sv | 20 ++
 rtl/mac_seq_tg_if.sv | 35 +++
 rtl/mac_r4_step.sv | 14 +
 rtl/mac_seq_tg.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types and helpers for the sequential MAC.
//   state_t   : FSM state encoding (IDLE, MULT, ACC, DONE).
//   cnt_width : bits needed to hold the values 0..max_val.
package mac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/mac_seq_tg_if.sv
// mac_seq_tg_if: operand and result handshakes of the sequential MAC.
//   g_input/e_input/clear/in_valid -> block, in_ready <- block
//   o/o_valid/ovf <- block,          o_ready -> block
//   dbg_state <- block (current FSM state, observation only)
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1; the producer holds its data stable
// while valid=1 and ready=0, and the consumer may change ready freely.
interface mac_seq_tg_if
    import mac_seq_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8,
    parameter int A = N + M + 4
) ();
    logic [N-1:0] g_input;
    logic [M-1:0] e_input;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [A-1:0] o;
    logic         o_valid;
    logic         o_ready;
    logic         ovf;
    state_t       dbg_state;

    modport slave (
        input  g_input, e_input, clear, in_valid, o_ready,
        output in_ready, o, o_valid, ovf, dbg_state
    );

    modport master (
        output g_input, e_input, clear, in_valid, o_ready,
        input  in_ready, o, o_valid, ovf, dbg_state
    );
endinterface

// File: rtl/mac_r4_step.sv
// mac_r4_step: one radix-4 partial product, d = g * x with x in 0..3,
// built from two AND masks and a shifted add (no multiplier).
//   g : N-bit unsigned multiplicand
//   x : 2-bit multiplier digit
//   d : N+2-bit product
module mac_r4_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] g,
    input  logic [1:0]   x,
    output logic [N+1:0] d
);
    assign d = {2'b00, g & {N{x[0]}}} + {1'b0, g & {N{x[1]}}, 1'b0};
endmodule

// File: rtl/mac_seq_tg.sv
// mac_seq_tg: sequential radix-4 multiply-accumulate.
// Multiplies g_input by e_input two multiplier bits per cycle, then adds
// (or, with clear=1, loads) the product into the accumulator.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mac_seq_tg_if.slave (operand and result handshakes)
// Optional build macro: MAC_SAT_EN -- saturate the accumulator to all
// ones on overflow instead of wrapping. ovf is sticky in both builds.
module mac_seq_tg
    import mac_seq_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8,
    parameter int A = N + M + 4
) (
    input  logic clk,
    input  logic rst,
    mac_seq_tg_if.slave bus
);
    localparam int            KW     = cnt_width(M / 2);
    localparam logic [KW-1:0] K_LAST = KW'(M / 2);

    state_t          state_q, state_d;
    logic [N-1:0]    g_q, g_d;
    logic [M-1:0]    e_q, e_d;
    logic            clr_q, clr_d;
    logic [KW-1:0]   k_q, k_d;
    logic [N+1:0]    dq_q, dq_d;
    logic [N+M-1:0]  p_q, p_d;
    logic [A-1:0]    acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d;
    logic            o_valid_q, o_valid_d;

    logic [N+1:0]    step_d;
    logic [N+1:0]    hi_sum;
    logic [N+M+1:0]  p_wide;
    logic [A:0]      acc_sum;

    // e_q shifts right two bits per step, so the current digit is always e_q[1:0].
    mac_r4_step #(.N(N)) u_step (
        .g (g_q),
        .x (e_q[1:0]),
        .d (step_d)
    );

    // The partial product is registered (dq_q) so the AND/shift network and
    // the N+2-bit adder sit in separate cycles. MULT therefore lasts M/2+1
    // cycles: k=0 only forms digit 0, k=M/2 only folds in the last digit.
    // The digit enters the top N+2 bits and the whole P shifts right by 2,
    // so digit j ends up weighted by 4^j.
    assign hi_sum  = {2'b00, p_q[N+M-1:M]} + dq_q;
    assign p_wide  = {hi_sum, p_q[M-1:0]};
    assign acc_sum = {1'b0, acc_q} + (A + 1)'(p_q);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        e_d     = e_q;
        clr_d   = clr_q;
        k_d     = k_q;
        dq_d    = dq_q;
        p_d     = p_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    g_d     = bus.g_input;
                    e_d     = bus.e_input;
                    clr_d   = bus.clear;
                    p_d     = '0;
                    k_d     = '0;
                    state_d = MULT;
                end
            end
            MULT: begin
                if (k_q != K_LAST) begin
                    dq_d = step_d;
                    e_d  = e_q >> 2;
                    k_d  = k_q + KW'(1);
                end
                if (k_q != '0) begin
                    p_d = p_wide[N+M+1:2];
                end
                if (k_q == K_LAST) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (clr_q) begin
                    acc_d = A'(p_q);
                    ovf_d = 1'b0;
                end else begin
                    ovf_d = ovf_q | acc_sum[A];
`ifdef MAC_SAT_EN
                    acc_d = acc_sum[A] ? '1 : acc_sum[A-1:0];
`else
                    acc_d = acc_sum[A-1:0];
`endif
                end
                state_d = DONE;
            end
            DONE: begin
                if (bus.o_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they align with state_q.
        in_ready_d = (state_d == IDLE);
        o_valid_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            g_q        <= '0;
            e_q        <= '0;
            clr_q      <= 1'b0;
            k_q        <= '0;
            dq_q       <= '0;
            p_q        <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            o_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            e_q        <= e_d;
            clr_q      <= clr_d;
            k_q        <= k_d;
            dq_q       <= dq_d;
            p_q        <= p_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            in_ready_q <= in_ready_d;
            o_valid_q  <= o_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.o         = acc_q;
    assign bus.o_valid   = o_valid_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;

endmodule
